// File: rtl/sha256_pkg.sv
// SHA-256 constants, controller state encoding and the round/schedule
// helpers shared by the simplified SHA-256 coprocessor.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    BLOCK,
    COMPUTE,
    UPDATE,
    WRITE,
    DONE
  } state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rightrotate(
    input logic [31:0] x,
    input int unsigned r
  );
    return (x >> r) | (x << (32 - r));
  endfunction

  // Returns the next {a,b,c,d,e,f,g,h}.
  function automatic logic [255:0] sha256_op(
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] c, input logic [31:0] d,
    input logic [31:0] e, input logic [31:0] f,
    input logic [31:0] g, input logic [31:0] h,
    input logic [31:0] w, input logic [31:0] k
  );
    logic [31:0] s0, s1, ch, maj, t1, t2;
    s1 = rightrotate(e, 6) ^ rightrotate(e, 11) ^ rightrotate(e, 25);
    ch = (e & f) ^ (~e & g);
    t1 = h + s1 + ch + k + w;
    s0 = rightrotate(a, 2) ^ rightrotate(a, 13) ^ rightrotate(a, 22);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t2 = s0 + maj;
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [31:0] wexpand(
    input logic [31:0] w16, input logic [31:0] w15,
    input logic [31:0] w7, input logic [31:0] w2
  );
    logic [31:0] sg0, sg1;
    sg0 = rightrotate(w15, 7) ^ rightrotate(w15, 18) ^ (w15 >> 3);
    sg1 = rightrotate(w2, 17) ^ rightrotate(w2, 19) ^ (w2 >> 10);
    return w16 + sg0 + w7 + sg1;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] w,
  input  logic [31:0] k,
  output logic [31:0] a_n,
  output logic [31:0] b_n,
  output logic [31:0] c_n,
  output logic [31:0] d_n,
  output logic [31:0] e_n,
  output logic [31:0] f_n,
  output logic [31:0] g_n,
  output logic [31:0] h_n
);

  assign {a_n, b_n, c_n, d_n, e_n, f_n, g_n, h_n} =
    sha256_op(a, b, c, d, e, f, g, h, w, k);

endmodule

// File: rtl/simplified_sha256_core.sv
// Memory-mapped SHA-256 coprocessor: reads an N-word message, pads it,
// hashes every block one round per cycle and writes the digest back.
module simplified_sha256_core
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int NUM_BLOCKS = (NUM_OF_WORDS + 2) / 16 + 1;
  localparam int LAST_IDX = NUM_BLOCKS * 16 - 1;
  localparam logic [31:0] LEN_BITS = 32'(NUM_OF_WORDS * 32);
  localparam logic [6:0] N7 = 7'(NUM_OF_WORDS);
  localparam logic [3:0] LAST_BLK = 4'(NUM_BLOCKS - 1);

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [3:0]  blk_q, blk_d;
  logic [15:0] out_base_q, out_base_d;
  logic [31:0] buf_q [NUM_OF_WORDS];
  logic [31:0] buf_d [NUM_OF_WORDS];
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic [31:0] v_q [8];
  logic [31:0] v_d [8];
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;

  logic [31:0] rnd [8];
  logic [31:0] h_sum [8];
  logic [31:0] pad_w [16];

  assign mem_clk        = clk;
  assign done           = done_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

  sha256_round u_round (
    .a   (v_q[0]),
    .b   (v_q[1]),
    .c   (v_q[2]),
    .d   (v_q[3]),
    .e   (v_q[4]),
    .f   (v_q[5]),
    .g   (v_q[6]),
    .h   (v_q[7]),
    .w   (win_q[0]),
    .k   (K[cnt_q[5:0]]),
    .a_n (rnd[0]),
    .b_n (rnd[1]),
    .c_n (rnd[2]),
    .d_n (rnd[3]),
    .e_n (rnd[4]),
    .f_n (rnd[5]),
    .g_n (rnd[6]),
    .h_n (rnd[7])
  );

  always_comb begin
    for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + v_q[i];
  end

  // Padded-stream view of the current block.
  always_comb begin
    int j;
    j = 0;
    for (int i = 0; i < 16; i++) begin
      j = int'(blk_q) * 16 + i;
      pad_w[i] = 32'h0;
      if (j == NUM_OF_WORDS) pad_w[i] = 32'h8000_0000;
      if (j == LAST_IDX) pad_w[i] = LEN_BITS;
      for (int m = 0; m < NUM_OF_WORDS; m++)
        if (j == m) pad_w[i] = buf_q[m];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    out_base_d  = out_base_q;
    buf_d       = buf_q;
    win_d       = win_q;
    h_d         = h_q;
    v_d         = v_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          out_base_d = output_addr;
          mem_addr_d = message_addr;
          h_d        = IV;
          cnt_d      = 7'd0;
          blk_d      = 4'd0;
          state_d    = READ;
        end
      end
      READ: begin
        // Data for the previous address arrives now; shift it in.
        if (cnt_q != 7'd0) begin
          for (int i = 0; i < NUM_OF_WORDS - 1; i++)
            buf_d[i] = buf_q[i + 1];
          buf_d[NUM_OF_WORDS - 1] = mem_read_data;
        end
        if (cnt_q == N7) begin
          state_d = BLOCK;
        end else begin
          cnt_d = cnt_q + 7'd1;
          if (cnt_q + 7'd1 < N7) mem_addr_d = mem_addr_q + 16'd1;
        end
      end
      BLOCK: begin
        win_d   = pad_w;
        v_d     = h_q;
        cnt_d   = 7'd0;
        state_d = COMPUTE;
      end
      COMPUTE: begin
        v_d = rnd;
        for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
        win_d[15] = wexpand(win_q[0], win_q[1], win_q[9], win_q[14]);
        if (cnt_q == 7'd63) state_d = UPDATE;
        else cnt_d = cnt_q + 7'd1;
      end
      UPDATE: begin
        h_d   = h_sum;
        blk_d = blk_q + 4'd1;
        if (blk_q == LAST_BLK) begin
          cnt_d       = 7'd0;
          mem_we_d    = 1'b1;
          mem_addr_d  = out_base_q;
          mem_wdata_d = h_sum[0];
          state_d     = WRITE;
        end else begin
          state_d = BLOCK;
        end
      end
      WRITE: begin
        if (cnt_q[2:0] == 3'd7) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d       = cnt_q + 7'd1;
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q + 16'd1;
          mem_wdata_d = h_q[cnt_q[2:0] + 3'd1];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      out_base_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < NUM_OF_WORDS; i++) buf_q[i] <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= '0;
        v_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      out_base_q  <= out_base_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      buf_q       <= buf_d;
      win_q       <= win_d;
      h_q         <= h_d;
      v_q         <= v_d;
    end
  end

endmodule

// File: tb/tb_simplified_sha256_core.sv
// Scoreboard bench: four core instances (N = 1, 13, 14, 30), each on its own
// memory, checked against a plain SHA-256 reference model.
module tb_simplified_sha256_core;

  localparam int NS [4] = '{1, 13, 14, 30};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct packed {
    logic [1:0]   inst;
    logic [15:0]  oaddr;
    logic [255:0] dig;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [4];
  logic [15:0] ma_v [4];
  logic [15:0] oa_v [4];
  logic        done_v [4];
  logic        mclk_v [4];
  logic        we_v [4];
  logic [15:0] addr_v [4];
  logic [31:0] wd_v [4];
  logic [31:0] rd_v [4];

  logic [31:0] mem [4][65536];
  logic        ld_we = 1'b0;
  int          ld_g = 0;
  logic [15:0] ld_a = '0;
  logic [31:0] ld_d = '0;

  exp_t sb [$];
  int   done_cnt [4];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    simplified_sha256_core #(.NUM_OF_WORDS(NS[gi])) u_dut (
      .clk            (clk),
      .reset_n        (rst),
      .start          (start_v[gi]),
      .message_addr   (ma_v[gi]),
      .output_addr    (oa_v[gi]),
      .done           (done_v[gi]),
      .mem_clk        (mclk_v[gi]),
      .mem_we         (we_v[gi]),
      .mem_addr       (addr_v[gi]),
      .mem_write_data (wd_v[gi]),
      .mem_read_data  (rd_v[gi])
    );
  end

  always @(posedge clk) begin
    if (ld_we) mem[ld_g][ld_a] <= ld_d;
    for (int g = 0; g < 4; g++) begin
      if (we_v[g]) mem[g][addr_v[g]] <= wd_v[g];
      rd_v[g] <= mem[g][addr_v[g]];
    end
  end

  // Reference model
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_ref(input logic [31:0] m [$], output int nblk);
    logic [31:0] s [$];
    logic [31:0] hv [8];
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, x, y;
    s = m;
    s.push_back(32'h80000000);
    while (s.size() % 16 != 14) s.push_back(32'h0);
    s.push_back(32'h0);
    s.push_back(32'(m.size() * 32));
    nblk = s.size() / 16;
    hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int bk = 0; bk < nblk; bk++) begin
      for (int t = 0; t < 64; t++) begin
        if (t < 16) w[t] = s[bk * 16 + t];
        else begin
          x = w[t-15];
          y = w[t-2];
          w[t] = w[t-16] + (rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3)) + w[t-7]
               + (rotr(y, 17) ^ rotr(y, 19) ^ (y >> 10));
        end
      end
      {a, b, c, d, e, f, g, h} = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
      for (int t = 0; t < 64; t++) begin
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1;
        d = c; c = b; b = a; a = t1 + t2;
      end
      hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
      hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
    end
    return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: write-region check and digest check on every done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (we_v[g]) begin
          n_chk++;
          if (sb.size() == 0 || sb[0].inst != 2'(g) || addr_v[g] < sb[0].oaddr ||
              int'(addr_v[g]) >= int'(sb[0].oaddr) + 8) begin
            n_fail++;
            $display("FAIL wr_range inst %0d: write addr %h, required within pending digest region",
                     g, addr_v[g]);
          end
        end
        if (done_v[g]) begin
          done_cnt[g]++;
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_unexpected inst %0d: done=1, required 0 (no run pending)", g);
          end else begin
            e = sb.pop_front();
            chk($sformatf("done_inst%0d", g), 32'(g), 32'(e.inst));
            for (int i = 0; i < 8; i++)
              chk($sformatf("digest_inst%0d_H%0d", g, i), mem[g][e.oaddr + 16'(i)],
                  e.dig[255 - 32*i -: 32]);
          end
        end
      end
    end
  end

  task automatic load_msg(input int g, input logic [15:0] base, input logic [31:0] m [$]);
    for (int i = 0; i < m.size(); i++) begin
      ld_g = g; ld_a = base + 16'(i); ld_d = m[i]; ld_we = 1'b1;
      @(posedge clk); #1;
    end
    ld_we = 1'b0;
  endtask

  task automatic push_exp(input int g, input logic [15:0] oa, input logic [255:0] dig);
    exp_t e;
    e.inst = 2'(g); e.oaddr = oa; e.dig = dig;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int g, inout int cyc);
    int lim;
    lim = cyc + 2000;
    while (cyc < lim) begin
      @(negedge clk);
      cyc++;
      if (done_v[g]) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout inst %0d: no done after 2000 cycles, required done", g);
  endtask

  task automatic run(input int g, input logic [15:0] ma, input logic [15:0] oa,
                     input logic [31:0] m [$], input int hold,
                     input logic [255:0] dig, input int nblk);
    int cyc, d0;
    load_msg(g, ma, m);
    push_exp(g, oa, dig);
    ma_v[g] = ma; oa_v[g] = oa;
    d0 = done_cnt[g];
    cyc = 0;
    start_v[g] = 1'b1;
    repeat (hold) @(posedge clk);
    cyc = hold;
    #1 start_v[g] = 1'b0;
    wait_done(g, cyc);
    n_chk++;
    if (cyc > m.size() + 70 * nblk + 12) begin
      n_fail++;
      $display("FAIL latency inst %0d: %0d cycles, required <= %0d", g, cyc, m.size() + 70 * nblk + 12);
    end
    repeat (5) @(posedge clk);
    #1 chk($sformatf("done_count_inst%0d", g), 32'(done_cnt[g] - d0), 32'd1);
  endtask

  initial begin
    logic [31:0] q [$];
    logic [31:0] qb [$];
    logic [31:0] w;
    logic [255:0] dig, dig_b;
    int nb, d0, cyc;
    for (int g = 0; g < 4; g++) begin
      start_v[g] = 1'b0; ma_v[g] = '0; oa_v[g] = '0; done_cnt[g] = 0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_done%0d", g), 32'(done_v[g]), 32'd0);
      chk($sformatf("rst_we%0d", g), 32'(we_v[g]), 32'd0);
      chk($sformatf("rst_addr%0d", g), 32'(addr_v[g]), 32'd0);
      chk($sformatf("rst_wdata%0d", g), wd_v[g], 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // N=1 "abcd" known answer
    q = '{32'h61626364};
    run(0, 16'd0, 16'd100, q, 1,
        256'h88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589, 1);

    // N=30 rotate-left sequence, three blocks
    q.delete();
    w = 32'h01234675;
    for (int i = 0; i < 30; i++) begin
      q.push_back(w);
      w = {w[30:0], w[31]};
    end
    dig = sha_ref(q, nb);
    run(3, 16'd0, 16'd1000, q, 1, dig, nb);

    // Padding boundaries, start held two cycles on N=13
    q.delete();
    for (int i = 0; i < 13; i++) q.push_back($urandom);
    dig = sha_ref(q, nb);
    run(1, 16'd200, 16'd500, q, 2, dig, nb);
    q.delete();
    for (int i = 0; i < 14; i++) q.push_back($urandom);
    dig = sha_ref(q, nb);
    run(2, 16'd50, 16'd900, q, 1, dig, nb);

    // Reset during COMPUTE, then a clean rerun
    q.delete();
    for (int i = 0; i < 30; i++) q.push_back($urandom);
    load_msg(3, 16'd1200, q);
    ma_v[3] = 16'd1200; oa_v[3] = 16'd1500;
    d0 = done_cnt[3];
    start_v[3] = 1'b1;
    @(posedge clk); #1 start_v[3] = 1'b0;
    repeat (60) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_done", 32'(done_v[3]), 32'd0);
    chk("abort_we", 32'(we_v[3]), 32'd0);
    chk("abort_addr", 32'(addr_v[3]), 32'd0);
    chk("abort_wdata", wd_v[3], 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (300) @(posedge clk);
    #1 chk("abort_no_done", 32'(done_cnt[3] - d0), 32'd0);
    dig = sha_ref(q, nb);
    run(3, 16'd1200, 16'd1500, q, 1, dig, nb);

    // Back-to-back runs on N=13 with start held across DONE
    q.delete(); qb.delete();
    for (int i = 0; i < 13; i++) begin
      q.push_back($urandom);
      qb.push_back($urandom);
    end
    load_msg(1, 16'd300, q);
    load_msg(1, 16'd400, qb);
    dig = sha_ref(q, nb);
    dig_b = sha_ref(qb, nb);
    push_exp(1, 16'd600, dig);
    push_exp(1, 16'd700, dig_b);
    d0 = done_cnt[1];
    ma_v[1] = 16'd300; oa_v[1] = 16'd600;
    start_v[1] = 1'b1;
    cyc = 0;
    wait_done(1, cyc);
    ma_v[1] = 16'd400; oa_v[1] = 16'd700;
    repeat (2) @(posedge clk);
    #1 start_v[1] = 1'b0;
    cyc = 0;
    wait_done(1, cyc);
    repeat (5) @(posedge clk);
    #1 chk("b2b_done_count", 32'(done_cnt[1] - d0), 32'd2);
    for (int i = 0; i < 8; i++)
      chk($sformatf("b2b_first_region_H%0d", i), mem[1][16'd600 + 16'(i)], dig[255 - 32*i -: 32]);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
